mul_div_unit: RTL

//  Parametrised iterative multiply/divide unit feeding the EX stage: MULT(U), MADD(U), MSUB(U), DIV(U).
//  One bit per cycle, shift-add for multiply and restoring division, with a final sign/accumulate step.

---
 rtl/mul_div_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide engine for the EX stage: MULT(U), MADD(U), MSUB(U), DIV(U).
// Shift-add multiply and restoring divide at one bit per cycle, then a sign/accumulate fix-up.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [2:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic [2*WIDTH-1:0]   hilo_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 div0_o
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state,  w_state_nxt;
  logic [2:0]       r_op,     w_op_nxt;
  logic             r_sign1,  w_sign1_nxt;
  logic             r_sign2,  w_sign2_nxt;
  logic [CW-1:0]    r_cnt,    w_cnt_nxt;
  logic [W2-1:0]    r_x,      w_x_nxt;      // multiplicand shifting left; quotient in low half
  logic [WIDTH-1:0] r_y,      w_y_nxt;      // multiplier shifting right; divisor held
  logic [W2-1:0]    r_acc,    w_acc_nxt;
  logic [WIDTH:0]   r_rem,    w_rem_nxt;
  logic [W2-1:0]    r_hilo,   w_hilo_nxt;
  logic [W2-1:0]    r_result, w_result_nxt;
  logic             r_ready,  w_ready_nxt;
  logic             r_busy,   w_busy_nxt;
  logic             r_div0,   w_div0_nxt;

  // Operand conditioning at accept: magnitudes only for signed ops
  logic             w_in_signed, w_in_div, w_in_neg1, w_in_neg2;
  logic [WIDTH-1:0] w_mag1, w_mag2;

  assign w_in_signed = ~op_i[0];
  assign w_in_div    = (op_i[2:1] == 2'b11);
  assign w_in_neg1   = w_in_signed & opdata1_i[WIDTH-1];
  assign w_in_neg2   = w_in_signed & opdata2_i[WIDTH-1];
  assign w_mag1      = w_in_neg1 ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
  assign w_mag2      = w_in_neg2 ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

  // Restoring-divide trial subtract; top bit of the difference is the borrow
  logic [WIDTH+1:0] w_shift, w_diff;
  logic             w_borrow;

  assign w_shift  = {r_rem, r_x[WIDTH-1]};
  assign w_diff   = w_shift - {2'b00, r_y};
  assign w_borrow = w_diff[WIDTH+1];

  // Sign correction and accumulate
  logic             w_neg_q;
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo, w_remf;
  logic [W2-1:0]    w_fixed;

  assign w_neg_q = ~r_op[0] & (r_sign1 ^ r_sign2);
  assign w_prod  = w_neg_q ? (~r_acc + W2'(1)) : r_acc;
  assign w_quo   = w_neg_q ? (~r_x[WIDTH-1:0] + WIDTH'(1)) : r_x[WIDTH-1:0];
  assign w_remf  = r_sign1 ? (~r_rem[WIDTH-1:0] + WIDTH'(1)) : r_rem[WIDTH-1:0];

  always_comb begin
    w_fixed = w_prod;
    case (r_op[2:1])
      2'b00:   w_fixed = w_prod;
      2'b01:   w_fixed = r_hilo + w_prod;
      2'b10:   w_fixed = r_hilo - w_prod;
      default: w_fixed = {w_remf, w_quo};
    endcase
  end

  // Next-state and register updates
  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_sign1_nxt  = r_sign1;
    w_sign2_nxt  = r_sign2;
    w_cnt_nxt    = r_cnt;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_acc_nxt    = r_acc;
    w_rem_nxt    = r_rem;
    w_hilo_nxt   = r_hilo;
    w_result_nxt = r_result;
    w_ready_nxt  = r_ready;
    w_busy_nxt   = r_busy;
    w_div0_nxt   = r_div0;

    case (r_state)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          w_op_nxt    = op_i;
          w_sign1_nxt = w_in_neg1;
          w_sign2_nxt = w_in_neg2;
          w_hilo_nxt  = hilo_i;
          w_cnt_nxt   = '0;
          w_x_nxt     = {{WIDTH{1'b0}}, w_mag1};
          w_y_nxt     = w_mag2;
          w_acc_nxt   = '0;
          w_rem_nxt   = '0;
          if (w_in_div && (opdata2_i == '0)) begin
            w_result_nxt = {opdata1_i, {WIDTH{1'b1}}};
            w_ready_nxt  = 1'b1;
            w_div0_nxt   = 1'b1;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = S_DONE;
          end else begin
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (annul_i) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_ready_nxt = 1'b0;
          w_div0_nxt  = 1'b0;
        end else if (r_cnt == CW'(WIDTH)) begin
          w_state_nxt = S_FIX;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_op[2:1] == 2'b11) begin
            w_rem_nxt = w_borrow ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
            w_x_nxt   = {r_x[W2-2:0], ~w_borrow};
          end else begin
            w_acc_nxt = r_y[0] ? (r_acc + r_x) : r_acc;
            w_x_nxt   = {r_x[W2-2:0], 1'b0};
            w_y_nxt   = {1'b0, r_y[WIDTH-1:1]};
          end
        end
      end

      S_FIX: begin
        if (annul_i) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_ready_nxt = 1'b0;
          w_div0_nxt  = 1'b0;
        end else begin
          w_result_nxt = w_fixed;
          w_busy_nxt   = 1'b0;
          w_ready_nxt  = 1'b1;
          w_state_nxt  = S_DONE;
        end
      end

      S_DONE: begin
        if (annul_i || !start_i) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_ready_nxt = 1'b0;
          w_div0_nxt  = 1'b0;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_sign1  <= 1'b0;
      r_sign2  <= 1'b0;
      r_cnt    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_hilo   <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_sign1  <= w_sign1_nxt;
      r_sign2  <= w_sign2_nxt;
      r_cnt    <= w_cnt_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_acc    <= w_acc_nxt;
      r_rem    <= w_rem_nxt;
      r_hilo   <= w_hilo_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
      r_busy   <= w_busy_nxt;
      r_div0   <= w_div0_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign busy_o   = r_busy;
  assign div0_o   = r_div0;

endmodule
